// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game stages: state encoding and screen/sprite geometry.
package flappy_pkg;

    // One-hot so the q_* outputs come straight from state flops
    typedef enum logic [2:0] {
        ST_INIT = 3'b001,
        ST_PLAY = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    localparam int SCREEN_H  = 480;
    localparam int BIRD_SIZE = 16;
    localparam int PIPE_W    = 40;
    localparam int GAP_H     = 120;

endpackage

// File: rtl/bird_hit_pipe.sv
// Two-stage geometry pipeline: stage 1 widens positions and forms box edges,
// stage 2 registers the individual comparisons; hit/pass are combined from stage 2.
module bird_hit_pipe
    import flappy_pkg::*;
(
    input  logic              Clk,
    input  logic              reset,
    input  logic              tick_valid,
    input  logic signed [9:0] Bird_X,
    input  logic signed [9:0] Bird_Y,
    input  logic signed [9:0] Pipe_X,
    input  logic        [9:0] Gap_Y,
    output logic              hit_v,
    output logic              pass_v,
    output logic              eval_valid
);

    logic signed [11:0] bx_w, by_w, px_w, gy_w;
    logic signed [11:0] bx, by, px, gy, br, bb, pr, gb;
    logic               v1, v2;
    logic               ceil_c, floor_c, xov_c, yout_c, pass_c;

    // Twelve bits leave headroom so edge sums never wrap
    assign bx_w = 12'(Bird_X);
    assign by_w = 12'(Bird_Y);
    assign px_w = 12'(Pipe_X);
    assign gy_w = $signed({2'b00, Gap_Y});

    always_ff @(posedge Clk) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= tick_valid;
            v2 <= v1;
        end
        bx <= bx_w;
        by <= by_w;
        px <= px_w;
        gy <= gy_w;
        br <= bx_w + 12'(BIRD_SIZE);
        bb <= by_w + 12'(BIRD_SIZE);
        pr <= px_w + 12'(PIPE_W);
        gb <= gy_w + 12'(GAP_H);

        ceil_c  <= (by < 12'sd0);
        floor_c <= (bb > 12'(SCREEN_H));
        xov_c   <= (br > px) && (bx < pr);
        yout_c  <= (by < gy) || (bb > gb);
        pass_c  <= (pr <= bx);
    end

    assign hit_v      = ceil_c | floor_c | (xov_c & yout_c);
    assign pass_v     = pass_c;
    assign eval_valid = v2;

endmodule

// File: rtl/bird_collision_ctrl.sv
// Game-state controller: INIT/PLAY/DONE FSM, sticky hit flag, passed flag and
// saturating score, driven by per-frame evaluations from bird_hit_pipe.
module bird_collision_ctrl
    import flappy_pkg::*;
#(
    parameter int SCORE_W = 8
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               Start,
    input  logic               Ack,
    input  logic               FrameTick,
    input  logic signed [9:0]  Bird_X,
    input  logic signed [9:0]  Bird_Y,
    input  logic signed [9:0]  Pipe_X,
    input  logic        [9:0]  Gap_Y,
    output logic               q_Init,
    output logic               q_Play,
    output logic               q_Done,
    output logic               Hit,
    output logic [SCORE_W-1:0] Score,
    output logic               ScorePulse
);

    state_t state;
    logic   passed;
    logic   tick_valid, hit_v, pass_v, eval_valid;

    assign tick_valid = FrameTick && (state == ST_PLAY);

    bird_hit_pipe u_geom (
        .Clk        (Clk),
        .reset      (reset),
        .tick_valid (tick_valid),
        .Bird_X     (Bird_X),
        .Bird_Y     (Bird_Y),
        .Pipe_X     (Pipe_X),
        .Gap_Y      (Gap_Y),
        .hit_v      (hit_v),
        .pass_v     (pass_v),
        .eval_valid (eval_valid)
    );

    // Evaluations arriving outside PLAY belong to a finished game and are dropped
    always_ff @(posedge Clk) begin
        if (reset) begin
            state      <= ST_INIT;
            Score      <= '0;
            Hit        <= 1'b0;
            ScorePulse <= 1'b0;
            passed     <= 1'b0;
        end else begin
            ScorePulse <= 1'b0;
            unique case (state)
                ST_INIT: begin
                    if (Start) begin
                        state  <= ST_PLAY;
                        Score  <= '0;
                        Hit    <= 1'b0;
                        passed <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (eval_valid) begin
                        if (hit_v) begin
                            state <= ST_DONE;
                            Hit   <= 1'b1;
                        end else if (pass_v) begin
                            if (!passed) begin
                                passed     <= 1'b1;
                                ScorePulse <= 1'b1;
                                if (Score != '1)
                                    Score <= Score + SCORE_W'(1);
                            end
                        end else begin
                            passed <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (Ack)
                        state <= ST_INIT;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign q_Init = (state == ST_INIT);
    assign q_Play = (state == ST_PLAY);
    assign q_Done = (state == ST_DONE);

endmodule

// File: tb/tb_bird_collision_ctrl.sv
// Directed and random stimulus for bird_collision_ctrl, checked against a
// frame-level game model; a second instance with a 2-bit score covers saturation.
module tb_bird_collision_ctrl;

    localparam int M_INIT = 0;
    localparam int M_PLAY = 1;
    localparam int M_DONE = 2;

    logic              Clk = 1'b0;
    logic              reset, Start, Ack, FrameTick;
    logic signed [9:0] Bird_X, Bird_Y, Pipe_X;
    logic        [9:0] Gap_Y;
    logic              q_Init, q_Play, q_Done, Hit, ScorePulse;
    logic        [7:0] Score;
    logic              q_Init2, q_Play2, q_Done2, Hit2, ScorePulse2;
    logic        [1:0] Score2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int cyc;
        bit hit;
        bit pass;
    } ev_t;

    ev_t pend[$];
    int  cyc = 0;
    int  mState = M_INIT;
    int  mScore = 0;
    int  mScore2 = 0;
    bit  mHit = 0;
    bit  mPulse = 0;
    bit  mPassed = 0;

    always #5 Clk = ~Clk;

    bird_collision_ctrl #(.SCORE_W(8)) dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .FrameTick(FrameTick),
        .Bird_X(Bird_X), .Bird_Y(Bird_Y), .Pipe_X(Pipe_X), .Gap_Y(Gap_Y),
        .q_Init(q_Init), .q_Play(q_Play), .q_Done(q_Done), .Hit(Hit),
        .Score(Score), .ScorePulse(ScorePulse)
    );

    bird_collision_ctrl #(.SCORE_W(2)) dut2 (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .FrameTick(FrameTick),
        .Bird_X(Bird_X), .Bird_Y(Bird_Y), .Pipe_X(Pipe_X), .Gap_Y(Gap_Y),
        .q_Init(q_Init2), .q_Play(q_Play2), .q_Done(q_Done2), .Hit(Hit2),
        .Score(Score2), .ScorePulse(ScorePulse2)
    );

    // Geometry straight from the game rules, in plain integers
    function automatic ev_t frameEval(input int c, input int bx, input int by,
                                      input int px, input int gy);
        ev_t e;
        bit  overlapX, outsideGap;
        overlapX   = (bx + 16 > px) && (bx < px + 40);
        outsideGap = (by < gy) || (by + 16 > gy + 120);
        e.cyc  = c;
        e.hit  = (by < 0) || (by + 16 > 480) || (overlapX && outsideGap);
        e.pass = (px + 40 <= bx);
        return e;
    endfunction

    task automatic modelStep();
        ev_t e;
        bit  have;
        int  prev;
        prev = mState;
        have = 0;
        if (reset) begin
            mState = M_INIT; mScore = 0; mScore2 = 0; mHit = 0; mPulse = 0; mPassed = 0;
            pend.delete();
        end else begin
            mPulse = 0;
            if (pend.size() > 0 && pend[0].cyc == cyc - 2) begin
                e = pend.pop_front();
                have = 1;
            end
            if (FrameTick && prev == M_PLAY)
                pend.push_back(frameEval(cyc, int'(Bird_X), int'(Bird_Y), int'(Pipe_X), int'(Gap_Y)));
            case (prev)
                M_INIT: if (Start) begin
                    mState = M_PLAY; mScore = 0; mScore2 = 0; mHit = 0; mPassed = 0;
                end
                M_PLAY: if (have) begin
                    if (e.hit) begin
                        mState = M_DONE;
                        mHit = 1;
                    end else if (e.pass) begin
                        if (!mPassed) begin
                            mPassed = 1;
                            mPulse = 1;
                            if (mScore < 255) mScore++;
                            if (mScore2 < 3) mScore2++;
                        end
                    end else begin
                        mPassed = 0;
                    end
                end
                default: if (Ack) mState = M_INIT;
            endcase
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic checkOutput();
        chk("q_Init",      {7'd0, q_Init},      8'(mState == M_INIT));
        chk("q_Play",      {7'd0, q_Play},      8'(mState == M_PLAY));
        chk("q_Done",      {7'd0, q_Done},      8'(mState == M_DONE));
        chk("Hit",         {7'd0, Hit},         8'(mHit));
        chk("Score",       Score,               8'(mScore));
        chk("ScorePulse",  {7'd0, ScorePulse},  8'(mPulse));
        chk("q_Play2",     {7'd0, q_Play2},     8'(mState == M_PLAY));
        chk("q_Done2",     {7'd0, q_Done2},     8'(mState == M_DONE));
        chk("q_Init2",     {7'd0, q_Init2},     8'(mState == M_INIT));
        chk("Hit2",        {7'd0, Hit2},        8'(mHit));
        chk("Score2",      {6'd0, Score2},      8'(mScore2));
        chk("ScorePulse2", {7'd0, ScorePulse2}, 8'(mPulse));
    endtask

    task automatic applyStimulus(input bit rst, input bit st, input bit ak, input bit ft,
                                 input int bx, input int by, input int px, input int gy);
        reset     = rst;
        Start     = st;
        Ack       = ak;
        FrameTick = ft;
        Bird_X    = 10'(bx);
        Bird_Y    = 10'(by);
        Pipe_X    = 10'(px);
        Gap_Y     = 10'(gy);
        @(posedge Clk);
        #1;
        modelStep();
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0, 100, 250, 400, 200);
    endtask

    task automatic tick(input int by, input int px);
        applyStimulus(0, 0, 0, 1, 100, by, px, 200);
    endtask

    task automatic restart();
        applyStimulus(0, 0, 1, 0, 100, 250, 400, 200);
        applyStimulus(0, 1, 0, 0, 100, 250, 400, 200);
    endtask

    initial begin
        $display("[TB] bird_collision_ctrl bench starting");
        applyStimulus(1, 0, 0, 0, 100, 250, 400, 200);
        applyStimulus(1, 0, 0, 1, 100, 250, 400, 200);
        applyStimulus(0, 0, 0, 1, 100, -1, 400, 200);
        idle(1);
        applyStimulus(0, 1, 0, 0, 100, 250, 400, 200);

        // Scoring: one pulse across 61,60,59, then a new pipe scores again
        tick(250, 61); tick(250, 60); tick(250, 59);
        tick(250, 400); tick(250, 60);
        idle(3);
        // Keep passing to reach 5 and saturate the 2-bit instance
        for (int i = 0; i < 3; i++) begin
            tick(250, 400); tick(250, 60);
        end
        idle(3);
        // Reset with a pass still in flight
        tick(250, 400); tick(250, 60);
        applyStimulus(1, 0, 0, 0, 100, 250, 400, 200);
        idle(3);

        // Ceiling hit, then Start held through DONE until Ack
        applyStimulus(0, 1, 0, 0, 100, 250, 400, 200);
        tick(250, 60);
        tick(-1, 400);
        idle(2);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 0, 1, 100, 250, 60, 200);
        applyStimulus(0, 1, 1, 0, 100, 250, 400, 200);
        applyStimulus(0, 1, 0, 0, 100, 250, 400, 200);

        // Floor boundary
        tick(464, 400); idle(3);
        tick(465, 400); idle(3);
        restart();

        // Pipe gap boundaries
        tick(199, 110); idle(3); restart();
        tick(200, 110); tick(304, 110); idle(3);
        tick(305, 110); idle(3); restart();

        // Pass and hit on the same tick: hit wins
        tick(-1, 60); idle(3); restart();

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(99, 0) == 0,
                          $urandom_range(3, 0) == 0,
                          $urandom_range(3, 0) == 0,
                          $urandom_range(1, 0) == 1,
                          int'($urandom_range(300, 0)),
                          int'($urandom_range(500, 0)) - 20,
                          int'($urandom_range(540, 0)) - 40,
                          int'($urandom_range(360, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
